camera_capture: RTL and testbench

Front-end capture stage between the OV7670 parallel bus and the dual-port M9K frame buffer. It samples PCLK/HREF/VSYNC/D[7:0] in the system clock domain and pairs RGB444 bytes into RGB332 pixels. It generates one single-cycle write per pixel with a linear address, for a 176x144 frame. Its write port connects directly to the frame buffer's write side; the VGA reader and image processor consume the stored frame downstream.

---
 rtl/camera_capture.sv | 133 +++++++++++++
 tb/tb_camera_capture.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/camera_capture.sv
// rtl/camera_capture.sv - OV7670 parallel-bus capture into RGB332 frame-buffer writes
module camera_capture #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int ADDR_W        = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PCLK,
    input  logic              HREF,
    input  logic              VSYNC,
    input  logic [7:0]        CAM_D,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [7:0]        W_DATA,
    output logic              W_EN,
    output logic              FRAME_DONE,
    output logic              OVERRUN
);
    localparam int XW = $clog2(SCREEN_WIDTH + 1);
    localparam int YW = $clog2(SCREEN_HEIGHT + 1);
    localparam logic [XW-1:0] X_MAX = XW'(SCREEN_WIDTH);
    localparam logic [YW-1:0] Y_MAX = YW'(SCREEN_HEIGHT);

    typedef enum logic [1:0] {SYNC, FRAME, BYTE0, BYTE1} state_t;

    state_t            state_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [2:0]        red_q;
    logic              wrote_q;
    logic [2:0]        pclk_sync_q;
    logic [2:0]        href_sync_q;
    logic [2:0]        vsync_sync_q;
    logic [7:0]        cam_d1_q;
    logic [7:0]        cam_d2_q;
    logic [7:0]        cam_d3_q;
    logic              pclk_rise_q;
    logic              href_fall_q;
    logic              vsync_rise_q;

    logic [ADDR_W-1:0] y_ext;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        pix_d;
    logic              in_window;
    logic              unused_bits;

    // y*176 as shift-add; the largest result (143*176+175) fits ADDR_W without wrap
    always_comb begin
        y_ext     = ADDR_W'(y_q);
        addr_d    = (y_ext << 7) + (y_ext << 5) + (y_ext << 4) + ADDR_W'(x_q);
        pix_d     = {red_q, cam_d3_q[7:5], cam_d3_q[3:2]};
        in_window = (x_q < X_MAX) && (y_q < Y_MAX);
    end

    assign unused_bits = cam_d3_q[4] ^ cam_d3_q[0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= SYNC;
            x_q          <= '0;
            y_q          <= '0;
            red_q        <= '0;
            wrote_q      <= 1'b0;
            pclk_sync_q  <= '0;
            href_sync_q  <= '0;
            vsync_sync_q <= '0;
            cam_d1_q     <= '0;
            cam_d2_q     <= '0;
            cam_d3_q     <= '0;
            pclk_rise_q  <= 1'b0;
            href_fall_q  <= 1'b0;
            vsync_rise_q <= 1'b0;
            W_ADDR       <= '0;
            W_DATA       <= '0;
            W_EN         <= 1'b0;
            FRAME_DONE   <= 1'b0;
            OVERRUN      <= 1'b0;
        end else begin
            pclk_sync_q  <= {pclk_sync_q[1:0], PCLK};
            href_sync_q  <= {href_sync_q[1:0], HREF};
            vsync_sync_q <= {vsync_sync_q[1:0], VSYNC};
            cam_d1_q     <= CAM_D;
            cam_d2_q     <= cam_d1_q;
            cam_d3_q     <= cam_d2_q;
            // Registered edges line up with cam_d3_q and href_sync_q[2]
            pclk_rise_q  <= pclk_sync_q[1] & ~pclk_sync_q[2];
            href_fall_q  <= ~href_sync_q[1] & href_sync_q[2];
            vsync_rise_q <= vsync_sync_q[1] & ~vsync_sync_q[2];

            W_EN       <= 1'b0;
            FRAME_DONE <= 1'b0;

            if (vsync_rise_q) begin
                state_q    <= FRAME;
                x_q        <= '0;
                y_q        <= '0;
                OVERRUN    <= 1'b0;
                FRAME_DONE <= wrote_q;
                wrote_q    <= 1'b0;
            end else begin
                case (state_q)
                    FRAME: begin
                        if (href_sync_q[2]) state_q <= BYTE0;
                    end
                    BYTE0, BYTE1: begin
                        if (href_fall_q) begin
                            x_q     <= '0;
                            if (y_q != Y_MAX) y_q <= y_q + 1'b1;
                            state_q <= FRAME;
                        end else if (pclk_rise_q && href_sync_q[2]) begin
                            if (state_q == BYTE0) begin
                                red_q   <= cam_d3_q[3:1];
                                state_q <= BYTE1;
                            end else begin
                                if (in_window) begin
                                    W_EN    <= 1'b1;
                                    W_ADDR  <= addr_d;
                                    W_DATA  <= pix_d;
                                    wrote_q <= 1'b1;
                                end else begin
                                    OVERRUN <= 1'b1;
                                end
                                if (x_q != X_MAX) x_q <= x_q + 1'b1;
                                state_q <= BYTE0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_camera_capture.sv
// tb/tb_camera_capture.sv - scoreboard bench for camera_capture
module tb_camera_capture;
    logic        clk = 1'b0;
    logic        rst;
    logic        pclk, href, vsync;
    logic [7:0]  cam_d;
    logic [14:0] w_addr;
    logic [7:0]  w_data;
    logic        w_en, frame_done, overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int mark_cyc = 0;
    bit lat_arm  = 1'b0;
    bit prev_wen = 1'b0;
    bit prev_done = 1'b0;
    int exp_addr[$];
    int exp_data[$];
    int pop_a, pop_d;

    // byte0, byte1 and the RGB332 pixel they must produce
    logic [7:0] tb0[4]  = '{8'h0A, 8'h02, 8'h08, 8'h00};
    logic [7:0] tb1[4]  = '{8'h5C, 8'h20, 8'h8C, 8'h00};
    logic [7:0] tpix[4] = '{8'hAB, 8'h24, 8'h93, 8'h00};

    camera_capture dut (
        .CLK(clk), .RESET(rst), .PCLK(pclk), .HREF(href), .VSYNC(vsync),
        .CAM_D(cam_d), .W_ADDR(w_addr), .W_DATA(w_data), .W_EN(w_en),
        .FRAME_DONE(frame_done), .OVERRUN(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (w_en && frame_done) check("done_write_overlap", 1, 0);
        if (w_en && prev_wen) check("wen_width", 2, 1);
        if (frame_done && prev_done) check("done_width", 2, 1);
        if (frame_done) done_cnt++;
        if (w_en) begin
            if (exp_addr.size() == 0) begin
                check("unexpected_write_addr", {17'd0, w_addr}, 32'hFFFF_FFFF);
            end else begin
                pop_a = exp_addr.pop_front();
                pop_d = exp_data.pop_front();
                check("w_addr", {17'd0, w_addr}, pop_a);
                check("w_data", {24'd0, w_data}, pop_d);
            end
            if (lat_arm) begin
                check("latency", cyc - mark_cyc, 4);
                lat_arm = 1'b0;
            end
        end
        prev_wen  = w_en;
        prev_done = frame_done;
    end

    task automatic clkn(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int a, input logic [7:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(int'(d));
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_d = b; pclk = 1'b1; clkn(2);
        pclk = 1'b0; clkn(2);
    endtask

    task automatic send_pixel(input int k, input bit wr, input int a);
        send_byte(tb0[k]);
        if (wr) push(a, tpix[k]);
        send_byte(tb1[k]);
    endtask

    task automatic href_on();
        href = 1'b1; clkn(4);
    endtask

    task automatic href_off();
        href = 1'b0; clkn(6);
    endtask

    task automatic vsync_pulse(input string name);
        vsync = 1'b1; clkn(4);
        vsync = 1'b0; clkn(4);
        check(name, done_cnt, exp_done);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_w_en"}, w_en, 0);
        check({tag, "_w_addr"}, {17'd0, w_addr}, 0);
        check({tag, "_w_data"}, {24'd0, w_data}, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        rst = 1'b1; pclk = 0; href = 0; vsync = 0; cam_d = 8'h00;
        clkn(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        clkn(2);
        check_reset_outputs("post_reset");

        // byte pairing and latency
        vsync_pulse("done_first_vsync");
        href_on();
        send_byte(8'h0A);
        push(0, 8'hAB);
        cam_d = 8'h5C; pclk = 1'b1; mark_cyc = cyc; lat_arm = 1'b1;
        clkn(2); pclk = 1'b0; clkn(2);
        href_off();
        check("latency_seen", lat_arm, 0);

        // line overrun: 180 pixels, only 176 stored
        exp_done++;
        vsync_pulse("done_after_pairing");
        href_on();
        for (int i = 0; i < 180; i++) begin
            send_pixel(i % 4, i < 176, i);
            if (i == 175) check("overrun_at_176", overrun, 0);
            if (i == 176) begin clkn(2); check("overrun_at_177", overrun, 1); end
        end
        href_off();
        href_on();
        send_pixel(2, 1, 176);
        href_off();
        check("overrun_sticky", overrun, 1);

        // odd byte then HREF drop
        exp_done++;
        vsync_pulse("done_after_overrun");
        check("overrun_cleared", overrun, 0);
        href_on();
        send_pixel(1, 1, 0);
        send_byte(8'h0A);
        href_off();
        href_on();
        send_pixel(2, 1, 176);
        href_off();

        // VSYNC rise coincident with a pixel-completing PCLK rise
        exp_done++;
        vsync_pulse("done_after_odd");
        href_on();
        send_pixel(0, 1, 0);
        send_byte(8'h0E);
        exp_done++;
        cam_d = 8'hEC; pclk = 1'b1; vsync = 1'b1; clkn(2);
        pclk = 1'b0; clkn(2);
        vsync = 1'b0; clkn(4);
        check("done_priority", done_cnt, exp_done);
        send_pixel(2, 1, 0);
        href_off();

        // reset mid-line after 10 pixels
        exp_done++;
        vsync_pulse("done_before_reset");
        href_on();
        for (int i = 0; i < 10; i++) send_pixel(i % 4, 1, i);
        send_byte(8'h0E);
        cam_d = 8'hEC; pclk = 1'b1; clkn(1);
        rst = 1'b1; clkn(2);
        check_reset_outputs("mid_reset");
        pclk = 1'b0; rst = 1'b0; clkn(2);
        for (int i = 0; i < 3; i++) send_pixel(0, 0, 0);
        href_off();
        check("sync_no_write_overrun", overrun, 0);
        vsync_pulse("done_after_reset");
        href_on();
        send_pixel(3, 1, 0);
        href_off();

        // frame sweep: 143 short lines then a full last line reaching 25343
        exp_done++;
        vsync_pulse("done_before_sweep");
        for (int y = 0; y < 143; y++) begin
            href_on();
            send_pixel(y % 4, 1, y * 176);
            href_off();
        end
        href_on();
        for (int x = 0; x < 176; x++) send_pixel(x % 4, 1, 143 * 176 + x);
        href_off();
        check("overrun_full_frame", overrun, 0);
        check("last_addr", {17'd0, w_addr}, 25343);
        href_on();
        send_pixel(0, 0, 0);
        clkn(2);
        check("overrun_line_145", overrun, 1);
        href_off();
        exp_done++;
        vsync_pulse("done_after_sweep");
        check("overrun_new_frame", overrun, 0);

        clkn(10);
        check("scoreboard_empty", exp_addr.size(), 0);
        check("frame_done_total", done_cnt, exp_done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
